// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for serial_subtractor.
// The ovf signal exists only when SERIAL_SUBTRACTOR_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start,
    output a,
    output b,
    output borrow_in,
    input  busy,
    input  done,
    input  diff,
    input  borrow_out
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    input  ovf
`endif
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    input  borrow_in,
    output busy,
    output done,
    output diff,
    output borrow_out
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output ovf
`endif
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - borrow_in, LSB first, one bit per clock, start/busy/done handshake.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed-overflow flag ovf.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, res_q, diff_q;
  logic [CntW-1:0]  cnt_q;
  logic             br_q, borrow_out_q;

  logic             accept, last;
  logic             a0, b0, d, br_next;
  logic [WIDTH-1:0] res_next;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic a_msb_q, b_msb_q, ovf_q;
  logic ovf_next;
`endif

  // start is honoured only when no operation is in flight
  assign accept = bus.start && (state_q == StIdle || state_q == StDone);
  assign last   = (state_q == StRun) && (cnt_q == CntLast);

  // Full-subtractor cell
  always_comb begin
    a0      = a_q[0];
    b0      = b_q[0];
    d       = a0 ^ b0 ^ br_q;
    br_next = (~a0 & b0) | (~(a0 ^ b0) & br_q);
    res_next           = res_q >> 1;
    res_next[WIDTH-1]  = d;
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  // d is the result MSB on the last RUN cycle
  assign ovf_next = (a_msb_q ^ b_msb_q) & (a_msb_q ^ d);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (last) state_d = StDone;
      StDone:  state_d = accept ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    bus.busy       = (state_q == StRun);
    bus.done       = (state_q == StDone);
    bus.diff       = diff_q;
    bus.borrow_out = borrow_out_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    bus.ovf        = ovf_q;
`endif
  end

  // Datapath: operand shift registers, borrow flop, counter, result hold
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      diff_q       <= '0;
      cnt_q        <= '0;
      br_q         <= 1'b0;
      borrow_out_q <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      ovf_q        <= 1'b0;
`endif
    end else if (accept) begin
      a_q   <= bus.a;
      b_q   <= bus.b;
      br_q  <= bus.borrow_in;
      res_q <= '0;
      cnt_q <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb_q <= bus.a[WIDTH-1];
      b_msb_q <= bus.b[WIDTH-1];
`endif
    end else if (state_q == StRun) begin
      a_q   <= a_q >> 1;
      b_q   <= b_q >> 1;
      br_q  <= br_next;
      res_q <= res_next;
      cnt_q <= cnt_q + CntW'(1);
      // Publish only the complete result so diff never shows partial bits
      if (last) begin
        diff_q       <= res_next;
        borrow_out_q <= br_next;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ovf_q        <= ovf_next;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed WIDTH=8 cases plus exhaustive WIDTH=4.
// Exercises ovf as well when SERIAL_SUBTRACTOR_OVF_EN is defined.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(4)) bus4 ();

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  typedef struct {
    logic [31:0] diff;
    logic        bo;
    logic        ovf;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];
  int   total = 0;
  int   bad   = 0;
  logic prev_done8 = 1'b0;
  logic prev_done4 = 1'b0;
  int   done_seen8 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, want, $time);
    end
  endtask

  function automatic exp_t model(input int unsigned w, input logic [31:0] a, input logic [31:0] b,
                                 input logic bin);
    exp_t        m;
    logic [32:0] full;
    logic [32:0] mask;
    full   = {1'b0, a} - {1'b0, b} - {32'd0, bin};
    mask   = (33'd1 << w) - 33'd1;
    m.diff = full[31:0] & mask[31:0];
    m.bo   = ({1'b0, a} < ({1'b0, b} + {32'd0, bin}));
    m.ovf  = (a[w-1] ^ b[w-1]) & (a[w-1] ^ m.diff[w-1]);
    return m;
  endfunction

  // Result monitors: pop one expectation per done pulse
  always @(negedge clk) begin
    exp_t e;
    if (bus8.done === 1'b1) begin
      done_seen8++;
      check("pulse8", {31'd0, prev_done8}, 32'd0);
      if (q8.size() == 0) begin
        check("spurious_done8", 32'd1, 32'd0);
      end else begin
        e = q8.pop_front();
        check("diff8", {24'd0, bus8.diff}, e.diff);
        check("borrow8", {31'd0, bus8.borrow_out}, {31'd0, e.bo});
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        check("ovf8", {31'd0, bus8.ovf}, {31'd0, e.ovf});
`endif
      end
    end
    prev_done8 = (bus8.done === 1'b1);
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus4.done === 1'b1) begin
      check("pulse4", {31'd0, prev_done4}, 32'd0);
      if (q4.size() == 0) begin
        check("spurious_done4", 32'd1, 32'd0);
      end else begin
        e = q4.pop_front();
        check("diff4", {28'd0, bus4.diff}, e.diff);
        check("borrow4", {31'd0, bus4.borrow_out}, {31'd0, e.bo});
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        check("ovf4", {31'd0, bus4.ovf}, {31'd0, e.ovf});
`endif
      end
    end
    prev_done4 = (bus4.done === 1'b1);
  end

  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic bin, input bit push);
    bus8.a         = a;
    bus8.b         = b;
    bus8.borrow_in = bin;
    bus8.start     = 1'b1;
    if (push) q8.push_back(model(8, {24'd0, a}, {24'd0, b}, bin));
  endtask

  task automatic go4(input logic [3:0] a, input logic [3:0] b, input logic bin);
    bus4.a         = a;
    bus4.b         = b;
    bus4.borrow_in = bin;
    bus4.start     = 1'b1;
    q4.push_back(model(4, {28'd0, a}, {28'd0, b}, bin));
  endtask

  task automatic drain8();
    for (int i = 0; i < 40 && q8.size() != 0; i++) @(negedge clk);
    if (q8.size() != 0) begin
      check("timeout8", q8.size(), 32'd0);
      q8.delete();
    end
  endtask

  task automatic drain4();
    for (int i = 0; i < 40 && q4.size() != 0; i++) @(negedge clk);
    if (q4.size() != 0) begin
      check("timeout4", q4.size(), 32'd0);
      q4.delete();
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    go8(a, b, bin, 1'b1);
    @(negedge clk);
    bus8.start = 1'b0;
    drain8();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int dones_before;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.borrow_in = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.borrow_in = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, bus8.busy}, 32'd0);
    check("rst_done", {31'd0, bus8.done}, 32'd0);
    check("rst_diff", {24'd0, bus8.diff}, 32'd0);
    check("rst_borrow", {31'd0, bus8.borrow_out}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Latency: busy for 8 cycles, done in the 9th
    go8(8'h05, 8'h03, 1'b0, 1'b1);
    @(negedge clk);
    bus8.start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      check("lat_busy", {31'd0, bus8.busy}, 32'd1);
      check("lat_nodone", {31'd0, bus8.done}, 32'd0);
      @(negedge clk);
    end
    check("lat_done", {31'd0, bus8.done}, 32'd1);
    check("lat_busy_off", {31'd0, bus8.busy}, 32'd0);
    @(negedge clk);

    run8(8'h00, 8'h01, 1'b0);
    run8(8'h80, 8'h01, 1'b0);
    run8(8'h10, 8'h0F, 1'b1);
    @(negedge clk);

    // start during RUN ignored; back-to-back start in DONE
    go8(8'h05, 8'h03, 1'b0, 1'b1);
    @(negedge clk);
    bus8.start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      check("ign_busy", {31'd0, bus8.busy}, 32'd1);
      if (k == 3) go8(8'hFF, 8'h00, 1'b0, 1'b0);
      if (k == 4) bus8.start = 1'b0;
      @(negedge clk);
    end
    check("ign_done", {31'd0, bus8.done}, 32'd1);
    go8(8'h22, 8'h11, 1'b0, 1'b1);
    @(negedge clk);
    bus8.start = 1'b0;
    check("b2b_busy", {31'd0, bus8.busy}, 32'd1);
    drain8();
    @(negedge clk);

    // Reset mid-RUN aborts without a done pulse
    go8(8'h33, 8'h11, 1'b0, 1'b0);
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'd0, bus8.busy}, 32'd0);
    check("abort_done", {31'd0, bus8.done}, 32'd0);
    check("abort_diff", {24'd0, bus8.diff}, 32'd0);
    check("abort_borrow", {31'd0, bus8.borrow_out}, 32'd0);
    dones_before = done_seen8;
    repeat (12) @(negedge clk);
    check("abort_no_done", done_seen8 - dones_before, 32'd0);
    run8(8'h33, 8'h11, 1'b0);

    for (int i = 0; i < 8; i++) begin
      run8(8'($urandom), 8'($urandom), 1'($urandom));
    end

    // Exhaustive WIDTH=4
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          go4(4'(a), 4'(b), 1'(c));
          @(negedge clk);
          bus4.start = 1'b0;
          drain4();
        end
      end
    end
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
